// File: rtl/decode_n_seq.sv
// Registered N-to-2^N decoder (one-hot / thermometer / inverted) with programmable hold and code sweep.
// Latency 1 cycle from acceptance to y; in_ready drops while holding (except the last hold cycle) and during a sweep.
module decode_n_seq #(
    parameter int N    = 4,
    parameter int M    = 1 << N,
    parameter int HOLD = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_code,
    input  logic [1:0]   mode,
    input  logic         sweep_start,
    output logic         sweep_busy,
    output logic         sweep_done,
    output logic [M-1:0] y,
    output logic         y_valid
);

    localparam int            CW         = ($clog2(HOLD + 1) > 1) ? $clog2(HOLD + 1) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(HOLD - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [N-1:0]  CODE_LAST  = N'(M - 1);
    localparam logic [N-1:0]  CODE_ONE   = N'(1);
    localparam logic [M-1:0]  Y_ONE      = M'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  code_q, code_d;
    logic [1:0]    mode_q, mode_d;
    logic [M-1:0]  y_q, y_d;
    logic          y_valid_q, y_valid_d;
    logic          sweep_busy_q, sweep_busy_d;
    logic          sweep_done_q, sweep_done_d;
    logic [N-1:0]  code_nxt;

    // Mode 2'b11 falls through to one-hot.
    function automatic logic [M-1:0] decode(input logic [N-1:0] c, input logic [1:0] md);
        logic [M-1:0] oh;
        oh = Y_ONE << c;
        case (md)
            2'b01:   decode = oh | (oh - Y_ONE);
            2'b10:   decode = ~oh;
            default: decode = oh;
        endcase
    endfunction

    assign code_nxt = code_q + CODE_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sweep_start) begin
                    state_d = ST_SWEEP;
                end else if (in_valid) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0 && !in_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (cnt_q == '0 && code_q == CODE_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: in_ready = !sweep_start;
                ST_HOLD: in_ready = (cnt_q == '0);
                default: in_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        code_d       = code_q;
        mode_d       = mode_q;
        y_d          = y_q;
        y_valid_d    = y_valid_q;
        sweep_busy_d = sweep_busy_q;
        sweep_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sweep_start) begin
                    code_d       = '0;
                    mode_d       = mode;
                    y_d          = decode('0, mode);
                    y_valid_d    = 1'b1;
                    sweep_busy_d = 1'b1;
                    cnt_d        = CNT_RELOAD;
                end else if (in_valid) begin
                    code_d    = in_code;
                    mode_d    = mode;
                    y_d       = decode(in_code, mode);
                    y_valid_d = 1'b1;
                    cnt_d     = CNT_RELOAD;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (in_valid) begin
                    code_d    = in_code;
                    mode_d    = mode;
                    y_d       = decode(in_code, mode);
                    y_valid_d = 1'b1;
                    cnt_d     = CNT_RELOAD;
                end else begin
                    y_d       = '0;
                    y_valid_d = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (code_q == CODE_LAST) begin
                    y_d          = '0;
                    y_valid_d    = 1'b0;
                    sweep_busy_d = 1'b0;
                    sweep_done_d = 1'b1;
                end else begin
                    code_d = code_nxt;
                    y_d    = decode(code_nxt, mode_q);
                    cnt_d  = CNT_RELOAD;
                end
            end
            default: begin
                y_d          = '0;
                y_valid_d    = 1'b0;
                sweep_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            code_q       <= '0;
            mode_q       <= '0;
            y_q          <= '0;
            y_valid_q    <= 1'b0;
            sweep_busy_q <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            mode_q       <= mode_d;
            y_q          <= y_d;
            y_valid_q    <= y_valid_d;
            sweep_busy_q <= sweep_busy_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign y          = y_q;
    assign y_valid    = y_valid_q;
    assign sweep_busy = sweep_busy_q;
    assign sweep_done = sweep_done_q;

endmodule

// File: doc/decode_n_seq.md
Name: decode_n_seq

Overview:
- Parametrised, registered successor to the combinational N-to-2^N decoder.
- Accepts a code over a valid/ready handshake and drives a registered 2^N-bit output in one of three modes: one-hot, thermometer or inverted one-hot.
- Holds each output for a programmable number of cycles.
- Built-in sweep mode steps through every code; used for output-enable fan-out and for self-test of downstream decode consumers.

Parameters:
- N, 4, input code width (N >= 1).
- M, 1<<N, output width; must equal 2^N.
- HOLD, 1, cycles each decoded output stays asserted (HOLD >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_code/mode are valid.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  N  code to decode.
- mode  input  2  00 one-hot, 01 thermometer, 10 inverted one-hot, 11 treated as 00.
- sweep_start  input  1  single-cycle request to sweep codes 0..M-1.
- sweep_busy  output  1  sweep in progress.
- sweep_done  output  1  one-cycle pulse when the sweep completes.
- y  output  M  registered decoded output.
- y_valid  output  1  y holds a decoded value.

Behaviour:
- All outputs are registers except in_ready, which is combinational from state, hold counter and rst.
- Reset values: y=0, y_valid=0, sweep_busy=0, sweep_done=0, state=IDLE, hold counter=0.
- in_ready=0 while rst=1.
- Decode functions, for code c:
  - one-hot: y[c]=1, all other bits 0.
  - thermometer: y[k]=1 for all k<=c, so c=M-1 gives all ones.
  - inverted: bitwise NOT of one-hot.
- Idle output is y=0 in every mode, including inverted.
- FSM states: IDLE, HOLD, SWEEP. The hold counter is ceil(log2(HOLD+1)) bits wide (minimum 1) and counts down.
- IDLE:
  - in_ready = !sweep_start.
  - If sweep_start=1: go to SWEEP; latch mode; y<=decode(0); y_valid<=1; sweep_busy<=1; cnt<=HOLD-1. in_valid is ignored that cycle (sweep has priority).
  - Else if in_valid=1: latch in_code and mode; y<=decode(in_code,mode); y_valid<=1; cnt<=HOLD-1; go to HOLD.
  - Latency: code accepted at edge t appears on y after edge t (visible in cycle t+1).
- HOLD:
  - in_ready=1 only when cnt==0, i.e. the last hold cycle.
  - cnt>0: decrement; y held.
  - cnt==0 with in_valid=1: accept the new code back-to-back; reload y and cnt; stay in HOLD; y_valid stays 1 with no gap.
  - cnt==0 with in_valid=0: y<=0, y_valid<=0, go to IDLE.
- SWEEP:
  - in_ready=0; sweep_start is ignored.
  - Each code is held HOLD cycles, then the code increments.
  - After code M-1 finishes its hold: y<=0, y_valid<=0, sweep_busy<=0, sweep_done<=1 for exactly one cycle, go to IDLE.
  - The sweep code counter is N bits; end is detected by comparison with M-1, never by overflow.
- mode and in_code changes while in HOLD or SWEEP have no effect on y; mode is latched only on acceptance or sweep_start.
- Reset mid-operation (any state): the next edge restores reset values. No sweep_done is issued for an aborted sweep.
- N=1 edge case: M=2; all rules above apply unchanged.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_code=3, sweep_start=1 -> y=0, y_valid=0, in_ready=0, sweep_busy=0 throughout; after rst drops, in_ready=1 in IDLE.
- One-hot, N=4, HOLD=1: in_code=5, mode=00, in_valid pulse -> next cycle y=16'h0020 with y_valid=1 for exactly 1 cycle, then y=0.
- Modes, N=4, HOLD=1:
  - thermometer code 3 -> 16'h000F.
  - thermometer code 15 -> 16'hFFFF.
  - inverted code 0 -> 16'hFFFE.
  - mode=11 code 9 -> 16'h0200.
- Back-to-back, HOLD=3: in_valid held with code 2 then code 7 -> y=16'h0004 for 3 cycles, then 16'h0080 for 3 cycles; y_valid continuously 1; in_ready high only in each third hold cycle.
- Sweep, HOLD=1, mode=00, sweep_start with in_valid=1 in the same cycle:
  - Sweep wins; in_ready=0.
  - y steps 16'h0001 to 16'h8000 over 16 cycles with sweep_busy=1.
  - sweep_done=1 and y=0 on the 17th cycle.
  - A second sweep_start mid-sweep is ignored.
- Reset mid-sweep: assert rst while y=16'h0040 -> next cycle y=0, sweep_busy=0, y_valid=0; sweep_done never pulses.
